// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 character LCD controller: command bytes,
// sequencer state codes and the init/address command table.
package lcd_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_CHARS = 32;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    typedef logic [2:0] state_t;

    localparam state_t ST_PWR_WAIT = 3'd0;
    localparam state_t ST_INIT     = 3'd1;
    localparam state_t ST_ADDR1    = 3'd2;
    localparam state_t ST_LINE1    = 3'd3;
    localparam state_t ST_ADDR2    = 3'd4;
    localparam state_t ST_LINE2    = 3'd5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Command byte sent for a given state/init step; data states return 0.
    function automatic logic [7:0] cmd_byte(input state_t st, input logic [1:0] step);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            ST_INIT: begin
                case (step)
                    2'd0:    b = CMD_FUNC_SET;
                    2'd1:    b = CMD_DISP_ON;
                    2'd2:    b = CMD_CLEAR;
                    default: b = CMD_ENTRY;
                endcase
            end
            ST_ADDR1: b = CMD_LINE1;
            ST_ADDR2: b = CMD_LINE2;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte HD44780 write engine: SETUP (E low), PULSE (E high), WAIT (E low),
// with the WAIT length chosen per byte (normal or clear-display).
module lcd_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int E_PULSE_CYC = 12,
    parameter int EXEC_CYC    = 2500,
    parameter int CLEAR_CYC   = 82000,
    parameter int CNT_W       = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic       long_wait,
    input  logic [7:0] data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       sample,
    output logic       done
);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_PULSE = 2'd2;
    localparam logic [1:0] PH_WAIT  = 2'd3;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic             e_q, e_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] wait_last;

    assign wait_last = long_q ? CLEAR_LAST : EXEC_LAST;
    assign sample    = (phase_q == PH_SETUP) && (cnt_q == SETUP_LAST);
    assign done      = (phase_q == PH_WAIT) && (cnt_q == wait_last);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CNT_W'(1);
        rs_d    = rs_q;
        long_d  = long_q;
        data_d  = data_q;
        case (phase_q)
            PH_SETUP: begin
                if (sample) begin
                    phase_d = PH_PULSE;
                    cnt_d   = '0;
                    // Character bytes arrive from the buffer only now, one cycle after the index.
                    if (rs_q) data_d = data;
                end
            end
            PH_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end
            end
            PH_WAIT: begin
                if (done) begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end
            end
            default: cnt_d = '0;
        endcase
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            rs_d    = rs;
            long_d  = long_wait;
            data_d  = data;
        end
        e_d = (phase_d == PH_PULSE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            e_q     <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            e_q     <= e_d;
            data_q  <= data_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller top: power-up wait, init sequence, then endless refresh of
// the 32-entry character buffer onto two 16-column lines.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int E_PULSE_CYC = 12,
    parameter int EXEC_CYC    = 2500,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] lcd_index,
    input  logic [7:0] lcd_char,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC),
                                  max_int(E_PULSE_CYC, EXEC_CYC)), CLEAR_CYC)) + 1;
    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYC - 1);
    localparam logic [4:0]       LAST_COL  = 5'(LCD_COLS - 1);
    localparam logic [4:0]       LAST_CHAR = 5'(LCD_CHARS - 1);

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [4:0]       char_q, char_d;
    logic [CNT_W-1:0] pwr_q, pwr_d;
    logic [4:0]       index_q, index_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    logic             xfer_start, xfer_rs, xfer_long, xfer_sample, xfer_done;
    logic [7:0]       cmd, xfer_data;

    // Transactions chain back to back: the next byte is launched on the done cycle.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        char_d       = char_q;
        pwr_d        = pwr_q;
        index_d      = index_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        xfer_start   = 1'b0;
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_q == PWR_LAST) begin
                    xfer_start = 1'b1;
                    state_d    = ST_INIT;
                    step_d     = 2'd0;
                end else begin
                    pwr_d = pwr_q + CNT_W'(1);
                end
            end
            ST_INIT: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    if (step_q == 2'd3) begin
                        state_d     = ST_ADDR1;
                        init_done_d = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            ST_ADDR1: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    state_d    = ST_LINE1;
                end
            end
            ST_LINE1: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    char_d     = char_q + 5'd1;
                    if (char_q == LAST_COL) state_d = ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    state_d    = ST_LINE2;
                end
            end
            ST_LINE2: begin
                if (xfer_done) begin
                    xfer_start = 1'b1;
                    char_d     = char_q + 5'd1;
                    if (char_q == LAST_CHAR) begin
                        state_d      = ST_ADDR1;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
        if (xfer_start && (state_d == ST_LINE1 || state_d == ST_LINE2)) index_d = char_d;
    end

    assign cmd       = cmd_byte(state_d, step_d);
    assign xfer_rs   = (state_d == ST_LINE1) || (state_d == ST_LINE2);
    assign xfer_long = !xfer_rs && (cmd == CMD_CLEAR);
    assign xfer_data = xfer_sample ? lcd_char : cmd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_PWR_WAIT;
            step_q       <= 2'd0;
            char_q       <= 5'd0;
            pwr_q        <= '0;
            index_q      <= 5'd0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            char_q       <= char_d;
            pwr_q        <= pwr_d;
            index_q      <= index_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    lcd_xfer #(
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC),
        .EXEC_CYC    (EXEC_CYC),
        .CLEAR_CYC   (CLEAR_CYC),
        .CNT_W       (CNT_W)
    ) u_xfer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (xfer_start),
        .rs        (xfer_rs),
        .long_wait (xfer_long),
        .data      (xfer_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data),
        .sample    (xfer_sample),
        .done      (xfer_done)
    );

    assign lcd_index  = index_q;
    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected strobes are derived from the
// transaction schedule and buffer contents; a monitor checks every E strobe.
module tb_lcd_ctrl;

    localparam int POWERUP  = 20;
    localparam int SETUP    = 2;
    localparam int PULSE    = 3;
    localparam int EXEC     = 5;
    localparam int CLEAR    = 10;
    localparam int T_CMD    = SETUP + PULSE + EXEC;
    localparam int T_CLR    = SETUP + PULSE + CLEAR;
    localparam int INIT_END = POWERUP + 3 * T_CMD + T_CLR;
    localparam int SLOTS    = 34;
    localparam int FRAME    = SLOTS * T_CMD;
    localparam int CHG_CYC  = INIT_END + 19 * T_CMD + 5;
    localparam int RST_CYC  = INIT_END + 3 * FRAME + 5 * T_CMD + SETUP + 1;

    typedef struct {
        int         rise;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] lcd_index;
    logic [7:0] lcd_char = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic       init_done, frame_done;

    logic [7:0] mem [32];
    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         rnd_en = 1'b0;
    bit         chg_en = 1'b0;

    lcd_ctrl #(
        .POWERUP_CYC (POWERUP),
        .SETUP_CYC   (SETUP),
        .E_PULSE_CYC (PULSE),
        .EXEC_CYC    (EXEC),
        .CLEAR_CYC   (CLEAR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_index  (lcd_index),
        .lcd_char   (lcd_char),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Character buffer with one cycle of read latency.
    always @(posedge clk) lcd_char <= mem[lcd_index];

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Which byte, if any, starts its SETUP phase in cycle c after reset.
    function automatic bit slot_at(input int c, output logic rs, output logic [7:0] d,
                                   output int idx);
        int j;
        rs = 1'b0; d = 8'h00; idx = 0;
        if (c == POWERUP)                        d = 8'h38;
        else if (c == POWERUP + T_CMD)           d = 8'h0C;
        else if (c == POWERUP + 2 * T_CMD)       d = 8'h01;
        else if (c == POWERUP + 2 * T_CMD + T_CLR) d = 8'h06;
        else if (c >= INIT_END && (c - INIT_END) % T_CMD == 0) begin
            j = ((c - INIT_END) / T_CMD) % SLOTS;
            if (j == 0)       d = 8'h80;
            else if (j == 17) d = 8'hC0;
            else begin
                rs  = 1'b1;
                idx = (j < 17) ? j - 1 : j - 2;
            end
        end else return 1'b0;
        return 1'b1;
    endfunction

    // Expectation generator and buffer writer.
    always @(negedge clk) begin
        exp_t       x;
        logic       rs;
        logic [7:0] d;
        int         idx;
        if (rst_n && cyc > 0) begin
            if (slot_at(cyc, rs, d, idx)) begin
                x.rise = cyc + SETUP;
                x.rs   = rs;
                x.data = rs ? mem[idx] : d;
                q.push_back(x);
            end
            if (chg_en && cyc == CHG_CYC) mem[17] = 8'h5A;
            else if (rnd_en && cyc >= INIT_END && (cyc - INIT_END) % T_CMD == 5
                     && $urandom_range(0, 2) == 0)
                mem[$urandom_range(0, 31)] = 8'($urandom_range(32, 126));
        end
    end

    // Monitor.
    bit         e_prev = 1'b0;
    logic       rs_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    int         e_len = 0;

    always @(negedge clk) begin
        exp_t x;
        check("rw_zero", 32'(lcd_rw), 0);
        if (cyc == 0) begin
            check("reset_state", 32'({lcd_e, lcd_rs, lcd_data, lcd_index, init_done, frame_done}), 0);
            e_prev = 1'b0;
            e_len  = 0;
        end else begin
            if (cyc < POWERUP) check("powerup_quiet", 32'({lcd_e, lcd_rs, lcd_data}), 0);
            check("init_done", 32'(init_done), 32'(cyc >= INIT_END));
            check("frame_done", 32'(frame_done),
                  32'(cyc >= INIT_END + FRAME && (cyc - INIT_END) % FRAME == 0));
            if (lcd_e && !e_prev) begin
                check("strobe_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    x = q.pop_front();
                    check("rise_cycle", cyc, x.rise);
                    check("strobe_rs", 32'(lcd_rs), 32'(x.rs));
                    check("strobe_data", 32'(lcd_data), 32'(x.data));
                end
                e_len = 1;
            end else if (lcd_e) begin
                check("hold_while_e", 32'({lcd_rs, lcd_data}), 32'({rs_prev, data_prev}));
                e_len++;
            end else if (e_prev) begin
                check("pulse_len", e_len, PULSE);
            end
            e_prev    = lcd_e;
            rs_prev   = lcd_rs;
            data_prev = lcd_data;
        end
    end

    task automatic wait_cyc(input int t);
        for (int k = 0; k < 5000 && cyc != t; k++) @(negedge clk);
        check("reach_cycle", cyc, t);
    endtask

    initial begin
        int overdue;
        rst_n  = 1'b0;
        chg_en = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(INIT_END + 2 * FRAME);
        rnd_en = 1'b1;
        // Reset lands in the middle of an E pulse.
        wait_cyc(RST_CYC);
        check("e_high_before_reset", 32'(lcd_e), 1);
        rst_n  = 1'b0;
        chg_en = 1'b0;
        q.delete();
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(32, 126));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(INIT_END + 2 * FRAME + 20);
        overdue = 0;
        foreach (q[k]) if (q[k].rise < cyc) overdue++;
        check("overdue_strobes", overdue, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
